// File: rtl/qspi_sram_pkg.sv
// Shared constants, state encoding and helpers for the QSPI SRAM arbiter.
package qspi_sram_pkg;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;
  localparam logic [7:0] SPI_CMD_EQIO  = 8'h38;

  localparam int NIB_CNT_W = 4;   // up to 8 nibbles per shifter segment
  localparam int SHIFT_W   = 32;  // 8 nibbles, MSB nibble goes out first
  localparam int GAP_W     = 8;

  typedef enum logic [3:0] {
    INIT, INIT_GAP, IDLE, CMD, ADDR, DUMMY, DATA, DONE, GAP
  } state_t;

  // One SPI-mode byte as 8 nibbles {1,1,0,bit}, the bit riding on sio0.
  function automatic logic [SHIFT_W-1:0] spi_byte_nibbles(input logic [7:0] b);
    logic [SHIFT_W-1:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[SHIFT_W-1-4*i -: 4] = {3'b110, b[7-i]};
    end
    return w;
  endfunction

endpackage

// File: rtl/qspi_sram_shifter.sv
// Nibble serialiser: two clk per nibble (sck low, then high), MSB nibble first,
// read nibbles captured on the clk edge that ends the sck-high phase.
module qspi_sram_shifter
  import qspi_sram_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [NIB_CNT_W-1:0] load_cnt,
  input  logic [SHIFT_W-1:0]   load_word,
  input  logic                 load_oe,
  input  logic [3:0]           sio_i,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          rx_next,
  output logic                 sck,
  output logic                 sio_oe,
  output logic [3:0]           sio_o
);

  logic                 active_q, active_d;
  logic                 phase_q, phase_d;
  logic                 sck_q, sck_d;
  logic                 oe_q, oe_d;
  logic [NIB_CNT_W-1:0] cnt_q, cnt_d;
  logic [SHIFT_W-1:0]   sh_q, sh_d;
  logic [15:0]          rx_q, rx_d;

  // Terminal count: last sck-high phase of the segment. The FSM may reload here
  // so consecutive segments run without a bubble.
  assign done    = active_q & phase_q & (cnt_q == NIB_CNT_W'(1));
  assign busy    = active_q;
  assign rx_next = {rx_q[11:0], sio_i};
  assign sck     = sck_q;
  assign sio_oe  = oe_q;
  assign sio_o   = sh_q[SHIFT_W-1 -: 4];

  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    sck_d    = sck_q;
    oe_d     = oe_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    if (active_q) begin
      if (!phase_q) begin
        phase_d = 1'b1;
        sck_d   = 1'b1;
      end else begin
        rx_d    = rx_next;
        phase_d = 1'b0;
        sck_d   = 1'b0;
        if (done) begin
          active_d = 1'b0;
          oe_d     = 1'b0;
          sh_d     = '0;
        end else begin
          cnt_d = cnt_q - NIB_CNT_W'(1);
          sh_d  = sh_q << 4;
        end
      end
    end
    if (load) begin
      active_d = 1'b1;
      phase_d  = 1'b0;
      sck_d    = 1'b0;
      oe_d     = load_oe;
      cnt_d    = load_cnt;
      sh_d     = load_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      sck_q    <= 1'b0;
      oe_q     <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      sck_q    <= sck_d;
      oe_q     <= oe_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: rtl/qspi_sram_arbiter.sv
// Two-port arbiter onto one SQI serial SRAM; port B (read-only) beats port A
// unless QSPI_ARB_RR_EN selects round-robin between simultaneous requests.
//
// state    | meaning
// INIT     | send EQIO (0x38) in SPI mode
// INIT_GAP | cs_n high CS_GAP cycles, then ready
// IDLE     | sample and arbitrate requests
// CMD      | load shifter, send read/write command
// ADDR     | 24-bit byte address
// DUMMY    | reads only, bus released
// DATA     | 16-bit data in or out
// DONE     | cs_n high, ack pulse, rdata update
// GAP      | remaining cs_n-high cycles
module qspi_sram_arbiter
  import qspi_sram_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int CS_GAP    = 2,
  parameter int INIT_EQIO = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  output logic              a_ack,
  output logic [15:0]       a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic [15:0]       b_rdata,
  output logic              ready,
  output logic              sram_cs_n,
  output logic              sram_sck,
  output logic              sram_sio_oe,
  output logic [3:0]        sram_sio_o,
  input  logic [3:0]        sram_sio_i
);

  state_t              state_q, state_d;
  logic                cs_n_q, cs_n_d;
  logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [15:0]         a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                ready_q, ready_d;
  logic                gnt_b_q, gnt_b_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                pick_b;
  logic                ld, ld_oe;
  logic [NIB_CNT_W-1:0] ld_cnt;
  logic [SHIFT_W-1:0]  ld_word;
  logic                sh_busy, sh_done;
  logic [15:0]         rx_next;
  logic [23:0]         byte_addr;

  assign byte_addr = 24'({addr_q, 1'b0});

`ifdef QSPI_ARB_RR_EN
  logic last_b_q, last_b_d;
  assign pick_b = b_req & (~a_req | ~last_b_q);
`else
  assign pick_b = b_req;
`endif

  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    ready_d   = ready_q;
    gnt_b_d   = gnt_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gap_d     = gap_q;
    ld        = 1'b0;
    ld_cnt    = '0;
    ld_word   = '0;
    ld_oe     = 1'b0;
`ifdef QSPI_ARB_RR_EN
    last_b_d  = last_b_q;
`endif
    case (state_q)
      INIT: begin
        if (!sh_busy) begin
          ld      = 1'b1;
          ld_cnt  = NIB_CNT_W'(8);
          ld_word = spi_byte_nibbles(SPI_CMD_EQIO);
          ld_oe   = 1'b1;
          cs_n_d  = 1'b0;
        end else if (sh_done) begin
          cs_n_d  = 1'b1;
          gap_d   = GAP_W'(CS_GAP - 1);
          state_d = INIT_GAP;
        end
      end
      INIT_GAP: begin
        if (gap_q == '0) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      IDLE: begin
        if (INIT_EQIO == 0) ready_d = 1'b1;
        if (ready_q && (a_req || b_req)) begin
          gnt_b_d = pick_b;
          we_d    = pick_b ? 1'b0 : a_we;
          addr_d  = pick_b ? b_addr : a_addr;
          wdata_d = a_wdata;
`ifdef QSPI_ARB_RR_EN
          last_b_d = pick_b;
`endif
          state_d = CMD;
        end
      end
      CMD: begin
        if (!sh_busy) begin
          ld      = 1'b1;
          ld_cnt  = NIB_CNT_W'(2);
          ld_word = {(we_q ? SQI_CMD_WRITE : SQI_CMD_READ), 24'h0};
          ld_oe   = 1'b1;
          cs_n_d  = 1'b0;
        end else if (sh_done) begin
          ld      = 1'b1;
          ld_cnt  = NIB_CNT_W'(6);
          ld_word = {byte_addr, 8'h0};
          ld_oe   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (sh_done) begin
          ld = 1'b1;
          if (we_q) begin
            ld_cnt  = NIB_CNT_W'(4);
            ld_word = {wdata_q, 16'h0};
            ld_oe   = 1'b1;
            state_d = DATA;
          end else begin
            ld_cnt  = NIB_CNT_W'(2);
            state_d = DUMMY;
          end
        end
      end
      DUMMY: begin
        if (sh_done) begin
          ld      = 1'b1;
          ld_cnt  = NIB_CNT_W'(4);
          state_d = DATA;
        end
      end
      DATA: begin
        if (sh_done) begin
          cs_n_d  = 1'b1;
          state_d = DONE;
          if (gnt_b_q) begin
            b_ack_d   = 1'b1;
            b_rdata_d = rx_next;
          end else begin
            a_ack_d = 1'b1;
            if (!we_q) a_rdata_d = rx_next;
          end
        end
      end
      DONE: begin
        if (CS_GAP <= 1) begin
          state_d = IDLE;
        end else begin
          gap_d   = GAP_W'(CS_GAP - 2);
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= (INIT_EQIO != 0) ? INIT : IDLE;
      cs_n_q    <= 1'b1;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      ready_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      gap_q     <= '0;
`ifdef QSPI_ARB_RR_EN
      last_b_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      ready_q   <= ready_d;
      gnt_b_q   <= gnt_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      gap_q     <= gap_d;
`ifdef QSPI_ARB_RR_EN
      last_b_q  <= last_b_d;
`endif
    end
  end

  qspi_sram_shifter u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (ld),
    .load_cnt  (ld_cnt),
    .load_word (ld_word),
    .load_oe   (ld_oe),
    .sio_i     (sram_sio_i),
    .busy      (sh_busy),
    .done      (sh_done),
    .rx_next   (rx_next),
    .sck       (sram_sck),
    .sio_oe    (sram_sio_oe),
    .sio_o     (sram_sio_o)
  );

  assign sram_cs_n = cs_n_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_qspi_sram_arbiter.sv
// Scoreboard bench for qspi_sram_arbiter with a behavioural SQI SRAM model.
`timescale 1ns/1ps
module tb_qspi_sram_arbiter;

  localparam int ADDR_W = 16;
  localparam int CS_GAP = 2;
  localparam int RD_LAT = 29;
  localparam int WR_LAT = 25;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              a_req = 1'b0, a_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [15:0]       a_wdata = '0;
  logic              a_ack;
  logic [15:0]       a_rdata;
  logic              b_req = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic              b_ack;
  logic [15:0]       b_rdata;
  logic              ready;
  logic              sram_cs_n, sram_sck, sram_sio_oe;
  logic [3:0]        sram_sio_o;
  logic [3:0]        sram_sio_i = 4'h0;

  always #5 clk = ~clk;

  qspi_sram_arbiter #(.ADDR_W(ADDR_W), .CS_GAP(CS_GAP), .INIT_EQIO(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_rdata(b_rdata),
    .ready(ready),
    .sram_cs_n(sram_cs_n), .sram_sck(sram_sck), .sram_sio_oe(sram_sio_oe),
    .sram_sio_o(sram_sio_o), .sram_sio_i(sram_sio_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic port_b; logic is_read; logic [15:0] rdata; int ack_cyc; } ack_exp_t;
  typedef struct { int kind; logic [23:0] addr; logic [15:0] data; } frame_t; // kind 0 init, 1 read, 2 write
  ack_exp_t ack_q[$];
  frame_t   frame_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- ack monitor ----------------
  always @(negedge clk) begin
    ack_exp_t e;
    if (reset_n === 1'b1 && (a_ack === 1'b1 || b_ack === 1'b1)) begin
      if (ack_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack actual a=%0b b=%0b required none", a_ack, b_ack);
      end else begin
        e = ack_q.pop_front();
        check("ack_port_b", b_ack, e.port_b);
        if (e.is_read) check("rdata", e.port_b ? b_rdata : a_rdata, e.rdata);
        if (e.ack_cyc >= 0) check("ack_latency_cyc", cyc, e.ack_cyc);
      end
    end
  end

  // ---------------- SRAM model ----------------
  logic [15:0] mem [logic [23:0]];
  logic [3:0]  nib [16];
  logic        nib_oe [16];
  int          n = 0;
  int          hi_cnt = 0;

  always @(posedge clk) hi_cnt <= (sram_cs_n === 1'b1) ? hi_cnt + 1 : 0;

  always @(negedge sram_cs_n) begin
    n = 0;
    check("cs_high_gap_ok", 32'(hi_cnt >= CS_GAP), 1);
  end

  always @(posedge sram_sck) begin
    logic [23:0] ra;
    logic [15:0] rw;
    if (n < 16) begin
      nib[n] = sram_sio_o;
      nib_oe[n] = sram_sio_oe;
    end
    if ({nib[0], nib[1]} == 8'h03 && n >= 10 && n <= 13) begin
      ra = {nib[2], nib[3], nib[4], nib[5], nib[6], nib[7]};
      rw = mem.exists(ra) ? mem[ra] : 16'h0000;
      sram_sio_i = 4'(rw >> (4 * (13 - n)));
    end
    n++;
  end

  always @(posedge sram_cs_n) begin
    frame_t      f;
    logic [7:0]  ib;
    logic [23:0] fa;
    int          bad;
    if (reset_n === 1'b1 && n > 0) begin
      if (frame_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_frame actual nibbles=%0d required none", n);
      end else begin
        f = frame_q.pop_front();
        bad = 0;
        ib = 8'h00;
        if (f.kind == 0) begin
          check("init_len", n, 8);
          for (int k = 0; k < 8; k++) begin
            ib = {ib[6:0], nib[k][0]};
            if (nib[k][3:1] !== 3'b110 || nib_oe[k] !== 1'b1) bad++;
          end
          check("init_byte", ib, 8'h38);
          check("init_upper_oe_bad", bad, 0);
        end else begin
          fa = {nib[2], nib[3], nib[4], nib[5], nib[6], nib[7]};
          check("frame_len", n, (f.kind == 1) ? 14 : 12);
          check("frame_cmd", {nib[0], nib[1]}, (f.kind == 1) ? 8'h03 : 8'h02);
          check("frame_addr", fa, f.addr);
          for (int k = 0; k < n && k < 16; k++)
            if (nib_oe[k] !== ((f.kind == 2) || (k < 8))) bad++;
          check("frame_oe_bad", bad, 0);
          if (f.kind == 2) begin
            check("frame_wdata", {nib[8], nib[9], nib[10], nib[11]}, f.data);
            mem[fa] = {nib[8], nib[9], nib[10], nib[11]};
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [23:0] baddr(input logic [15:0] w);
    return {7'b0, w, 1'b0};
  endfunction

  task automatic push_ack(input logic pb, input logic rd, input logic [15:0] d, input int lat);
    ack_exp_t e;
    e.port_b = pb; e.is_read = rd; e.rdata = d;
    e.ack_cyc = (lat < 0) ? -1 : cyc + 1 + lat;
    ack_q.push_back(e);
  endtask

  task automatic push_frame(input int kind, input logic [23:0] a, input logic [15:0] d);
    frame_t f;
    f.kind = kind; f.addr = a; f.data = d;
    frame_q.push_back(f);
  endtask

  task automatic a_xfer(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    int t = 0;
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    while (a_ack !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    check("a_ack_in_time", 32'(t < 400), 1);
    a_req = 1'b0;
  endtask

  task automatic b_xfer(input logic [15:0] addr);
    int t = 0;
    b_req = 1'b1; b_addr = addr;
    while (b_ack !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    check("b_ack_in_time", 32'(t < 400), 1);
    b_req = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_init;
    int t = 0;
    while (sram_cs_n !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    while (sram_cs_n !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    check("init_cs_seen", 32'(t < 100), 1);
    t = 0;
    while (ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("ready_after_cs_gap", t, CS_GAP);
  endtask

  logic [15:0] b2b_addr [3] = '{16'h0020, 16'h0021, 16'h0022};
  logic [15:0] b2b_data [3] = '{16'hA5A5, 16'h5A5A, 16'h0FF0};

  // ---------------- main sequence ----------------
  initial begin
    int t;
    mem[24'h000020] = 16'h1234;
    for (int k = 0; k < 3; k++) mem[baddr(b2b_addr[k])] = b2b_data[k];
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cs_n", sram_cs_n, 1);
    check("rst_sck", sram_sck, 0);
    check("rst_oe", sram_sio_oe, 0);
    check("rst_sio_o", sram_sio_o, 0);
    check("rst_acks", {a_ack, b_ack}, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);
    check("rst_ready", ready, 0);

    // 1: EQIO init and ready timing
    push_frame(0, 24'h0, 16'h0);
    reset_n = 1'b1;
    wait_init();
    idle_cycles(3);

    // 2: A write, then read it back
    push_frame(2, baddr(16'h0123), 16'hBEEF);
    push_ack(1'b0, 1'b0, 16'h0, WR_LAT);
    a_xfer(1'b1, 16'h0123, 16'hBEEF);
    idle_cycles(4);
    push_frame(1, baddr(16'h0123), 16'h0);
    push_ack(1'b0, 1'b1, 16'hBEEF, RD_LAT);
    a_xfer(1'b0, 16'h0123, 16'h0);
    idle_cycles(4);

    // 3: B read
    push_frame(1, 24'h000020, 16'h0);
    push_ack(1'b1, 1'b1, 16'h1234, RD_LAT);
    b_xfer(16'h0010);
    idle_cycles(4);

    // 4: simultaneous requests
`ifdef QSPI_ARB_RR_EN
    push_frame(1, baddr(16'h0123), 16'h0);
    push_frame(1, 24'h000020, 16'h0);
    push_ack(1'b0, 1'b1, 16'hBEEF, RD_LAT);
    push_ack(1'b1, 1'b1, 16'h1234, -1);
`else
    push_frame(1, 24'h000020, 16'h0);
    push_frame(1, baddr(16'h0123), 16'h0);
    push_ack(1'b1, 1'b1, 16'h1234, RD_LAT);
    push_ack(1'b0, 1'b1, 16'hBEEF, -1);
`endif
    fork
      a_xfer(1'b0, 16'h0123, 16'h0);
      b_xfer(16'h0010);
    join
    idle_cycles(4);

    // 5: reset during ADDR of an A write
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0200; a_wdata = 16'hCAFE;
    idle_cycles(10);
    #2 reset_n = 1'b0;
    #1;
    check("abort_cs_n", sram_cs_n, 1);
    check("abort_sck_oe", {sram_sck, sram_sio_oe}, 0);
    check("abort_rdata", {a_rdata, b_rdata}, 0);
    check("abort_ready", ready, 0);
    a_req = 1'b0;
    idle_cycles(2);
    push_frame(0, 24'h0, 16'h0);
    reset_n = 1'b1;
    wait_init();
    idle_cycles(3);
    push_frame(2, baddr(16'h0200), 16'hCAFE);
    push_ack(1'b0, 1'b0, 16'h0, WR_LAT);
    a_xfer(1'b1, 16'h0200, 16'hCAFE);
    idle_cycles(4);
    push_frame(1, baddr(16'h0200), 16'h0);
    push_ack(1'b0, 1'b1, 16'hCAFE, RD_LAT);
    a_xfer(1'b0, 16'h0200, 16'h0);
    idle_cycles(4);

    // 6: B request held across three back-to-back reads
    for (int k = 0; k < 3; k++) begin
      push_frame(1, baddr(b2b_addr[k]), 16'h0);
      push_ack(1'b1, 1'b1, b2b_data[k], (k == 0) ? RD_LAT : -1);
    end
    b_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_addr = b2b_addr[k];
      t = 0;
      @(negedge clk);
      while (b_ack !== 1'b1 && t < 400) begin @(negedge clk); t++; end
      check("b2b_ack_in_time", 32'(t < 400), 1);
    end
    b_req = 1'b0;
    idle_cycles(10);

    check("ack_queue_empty", ack_q.size(), 0);
    check("frame_queue_empty", frame_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
